lsu_router: RTL and testbench
=============================

LSU_ROUTER -- requirements
Module: lsu_router

Interface
REQ-001 Parameter DATA_W, default 64, operand/result width in bits, SHALL be 8..128.
REQ-002 Parameter FIFO_DEPTH, default 4, write-back FIFO entries, SHALL be a power of 2 and at least 2.
REQ-003 clk  input  1  single clock; all logic SHALL update on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 rd_valid/rd_ready  input/output  1/1  read-request handshake.
REQ-006 rd_sel  input  2  operand source: 00 mem, 01 vrf, 10 user, 11 reserved.
REQ-007 mem_op1, mem_op2, vrf_op1, vrf_op2, usr_op1, usr_op2  input  DATA_W each  source operand pairs.
REQ-008 op_valid/op_ready  output/input  1/1  operand handshake toward the compute unit.
REQ-009 op1, op2  output  DATA_W each  registered operands.
REQ-010 wb_valid/wb_ready  input/output  1/1  compute-result handshake.
REQ-011 wb_sel  input  2  destination: 00 mem, 01 vrf, 10 or 11 user.
REQ-012 wb_data  input  DATA_W  compute result.
REQ-013 mem_wvalid, vrf_wvalid, usr_wvalid  output  1 each  one-hot destination strobes.
REQ-014 wdata  output  DATA_W  FIFO head data.
REQ-015 dst_ready  input  1  the selected destination accepts the head entry.
REQ-016 err_sel  output  1  sticky flag: a read request with rd_sel=11 was seen.

Function
REQ-017 rd_ready SHALL equal (!op_valid || op_ready), combinationally.
REQ-018 A read is accepted when rd_valid && rd_ready; for rd_sel 00/01/10, op1/op2 SHALL capture the selected pair and op_valid SHALL be 1 on the next cycle (latency 1).
REQ-019 An accepted read with rd_sel=11 SHALL be dropped: op1/op2 unchanged, op_valid cleared if consumed that cycle, err_sel set to 1 until reset.
REQ-020 If op_ready && op_valid with no accepted read, op_valid SHALL clear next cycle; accept plus consume in one cycle SHALL keep op_valid=1 with new data, no bubble.
REQ-021 While op_valid && !op_ready, op1/op2/op_valid SHALL hold.
REQ-022 Write-back FIFO SHALL store {wb_sel, wb_data}; wb_ready SHALL equal !full, combinationally.
REQ-023 Push occurs when wb_valid && wb_ready; the pushed entry SHALL be visible at the head no earlier than the next cycle (no fall-through).
REQ-024 When non-empty, exactly one strobe SHALL be 1, decoded from the head wb_sel; wdata SHALL equal the head data; all strobes SHALL be 0 when empty.
REQ-025 Pop occurs when non-empty && dst_ready; dst_ready SHALL be ignored when empty.
REQ-026 Simultaneous push and pop SHALL leave the occupancy unchanged; when full, push SHALL be blocked even if a pop occurs in the same cycle.
REQ-027 Read/write pointers SHALL wrap modulo FIFO_DEPTH; occupancy counter SHALL be clog2(FIFO_DEPTH)+1 bits wide.
REQ-028 Read path and write path SHALL operate independently and concurrently.

Reset
REQ-029 With rst=1, op_valid, op1, op2, err_sel, and all strobes SHALL be 0 and the FIFO SHALL be empty on the next edge; in-flight operands and entries SHALL be discarded.
REQ-030 During rst, rd_ready and wb_ready SHALL be ignored by upstream; after release, wb_ready SHALL be 1 and rd_ready SHALL be 1.

Configuration
REQ-031 Macro LSU_ROUTER_PERF_EN defined: add outputs rd_cnt[31:0] (accepted valid reads) and wb_cnt[31:0] (pops); both wrap at 2^32 and are cleared by rst.
REQ-032 Macro LSU_ROUTER_PERF_EN undefined: these ports and counters SHALL be absent; all other behaviour identical.

Verification
REQ-033 rd_sel=01, vrf_op1=0xA5, vrf_op2=0x5A, op_ready=1 -> next cycle op_valid=1, op1=0xA5, op2=0x5A.
REQ-034 op_ready=0, two reads (mem, then user) -> first held; rd_ready=0; second accepted only after op_ready pulse; no data lost.
REQ-035 rd_sel=11 accepted -> err_sel=1, op_valid=0, op1/op2 unchanged; rst -> err_sel=0.
REQ-036 dst_ready=0, push 5 entries at FIFO_DEPTH=4 -> wb_ready=0 after 4th; 5th stalls; then dst_ready=1 -> strobes/wdata drain in push order, wb_sel=11 entry drives usr_wvalid.
REQ-037 FIFO with 2 entries, push and pop every cycle for 10 cycles -> occupancy stays 2, pointers wrap, order preserved.
REQ-038 rst asserted with op_valid=1 and 3 FIFO entries -> next cycle op_valid=0, all strobes 0, wb_ready=1; with PERF_EN, counters read 0.

Source files
------------

// File: rtl/lsu_router.sv
// Load/store operand router: registered operand select toward compute, plus a write-back FIFO to mem/vrf/user.
// Optional performance counters (rd_cnt, wb_cnt) are built when LSU_ROUTER_PERF_EN is defined.
module lsu_router #(
    parameter int DATA_W     = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [1:0]        rd_sel,
    input  logic [DATA_W-1:0] mem_op1,
    input  logic [DATA_W-1:0] mem_op2,
    input  logic [DATA_W-1:0] vrf_op1,
    input  logic [DATA_W-1:0] vrf_op2,
    input  logic [DATA_W-1:0] usr_op1,
    input  logic [DATA_W-1:0] usr_op2,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [DATA_W-1:0] op1,
    output logic [DATA_W-1:0] op2,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [1:0]        wb_sel,
    input  logic [DATA_W-1:0] wb_data,
    output logic              mem_wvalid,
    output logic              vrf_wvalid,
    output logic              usr_wvalid,
    output logic [DATA_W-1:0] wdata,
    input  logic              dst_ready,
    output logic              err_sel
`ifdef LSU_ROUTER_PERF_EN
    ,
    output logic [31:0]       rd_cnt,
    output logic [31:0]       wb_cnt
`endif
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int EW = DATA_W + 2;

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // valid never waits on ready, and ready may depend on valid only through the stage's own state.

    // ---------------- read path ----------------
    logic              rd_acc;
    logic [DATA_W-1:0] sel_op1;
    logic [DATA_W-1:0] sel_op2;

    assign rd_ready = !op_valid || op_ready;
    assign rd_acc   = rd_valid && rd_ready;

    always_comb begin
        sel_op1 = mem_op1;
        sel_op2 = mem_op2;
        case (rd_sel)
            2'b01:   begin sel_op1 = vrf_op1; sel_op2 = vrf_op2; end
            2'b10:   begin sel_op1 = usr_op1; sel_op2 = usr_op2; end
            default: begin sel_op1 = mem_op1; sel_op2 = mem_op2; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_valid <= 1'b0;
            op1      <= '0;
            op2      <= '0;
            err_sel  <= 1'b0;
        end else if (rd_acc) begin
            // Reserved source is dropped; any slot it freed (consumed this cycle) stays empty.
            if (rd_sel == 2'b11) begin
                op_valid <= 1'b0;
                err_sel  <= 1'b1;
            end else begin
                op_valid <= 1'b1;
                op1      <= sel_op1;
                op2      <= sel_op2;
            end
        end else if (op_valid && op_ready) begin
            op_valid <= 1'b0;
        end
    end

    // ---------------- write-back FIFO ----------------
    logic [EW-1:0] fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [EW-1:0] head;

    assign full     = (count == CW'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign wb_ready = !full;
    assign push     = wb_valid && !full;
    assign pop      = !empty && dst_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {wb_sel, wb_data};
    end

    assign head  = fifo_mem[rd_ptr];
    assign wdata = head[DATA_W-1:0];

    always_comb begin
        mem_wvalid = 1'b0;
        vrf_wvalid = 1'b0;
        usr_wvalid = 1'b0;
        if (!empty) begin
            case (head[EW-1:DATA_W])
                2'b00:   mem_wvalid = 1'b1;
                2'b01:   vrf_wvalid = 1'b1;
                default: usr_wvalid = 1'b1;
            endcase
        end
    end

`ifdef LSU_ROUTER_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt <= '0;
            wb_cnt <= '0;
        end else begin
            if (rd_acc && rd_sel != 2'b11) rd_cnt <= rd_cnt + 32'd1;
            if (pop)                       wb_cnt <= wb_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_lsu_router.sv
// Self-checking bench for lsu_router: directed scenarios plus random traffic against a queue-based reference model.
module tb_lsu_router;

    localparam int DW    = 64;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          rd_valid;
    logic          rd_ready;
    logic [1:0]    rd_sel;
    logic [DW-1:0] mem_op1, mem_op2, vrf_op1, vrf_op2, usr_op1, usr_op2;
    logic          op_valid;
    logic          op_ready;
    logic [DW-1:0] op1, op2;
    logic          wb_valid;
    logic          wb_ready;
    logic [1:0]    wb_sel;
    logic [DW-1:0] wb_data;
    logic          mem_wvalid, vrf_wvalid, usr_wvalid;
    logic [DW-1:0] wdata;
    logic          dst_ready;
    logic          err_sel;
`ifdef LSU_ROUTER_PERF_EN
    logic [31:0]   rd_cnt, wb_cnt;
    logic [31:0]   m_rd_cnt, m_wb_cnt;
`endif

    lsu_router #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_sel(rd_sel),
        .mem_op1(mem_op1), .mem_op2(mem_op2),
        .vrf_op1(vrf_op1), .vrf_op2(vrf_op2),
        .usr_op1(usr_op1), .usr_op2(usr_op2),
        .op_valid(op_valid), .op_ready(op_ready), .op1(op1), .op2(op2),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_sel(wb_sel), .wb_data(wb_data),
        .mem_wvalid(mem_wvalid), .vrf_wvalid(vrf_wvalid), .usr_wvalid(usr_wvalid),
        .wdata(wdata), .dst_ready(dst_ready), .err_sel(err_sel)
`ifdef LSU_ROUTER_PERF_EN
        , .rd_cnt(rd_cnt), .wb_cnt(wb_cnt)
`endif
    );

    // clock / reset
    always #5 clk = ~clk;

    // scoreboard / reference model state
    int            n_checks = 0;
    int            n_errors = 0;
    logic          m_valid;
    logic [DW-1:0] m_op1, m_op2;
    logic          m_err;
    logic [DW+1:0] exp_q[$];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_op1   = '0;
        m_op2   = '0;
        m_err   = 1'b0;
        exp_q.delete();
`ifdef LSU_ROUTER_PERF_EN
        m_rd_cnt = '0;
        m_wb_cnt = '0;
`endif
    endtask

    // Called just after a falling edge with inputs applied: check outputs, advance model, cross a rising edge.
    task automatic cycle();
        logic          exp_rd_ready;
        logic [1:0]    hsel;
        logic          acc;
        logic          pop;
        logic          push;
        #1;
        exp_rd_ready = !m_valid || op_ready;
        check("op_valid", op_valid, m_valid);
        check("op1", op1, m_op1);
        check("op2", op2, m_op2);
        check("err_sel", err_sel, m_err);
        if (!rst) begin
            check("rd_ready", rd_ready, exp_rd_ready);
            check("wb_ready", wb_ready, exp_q.size() < DEPTH);
        end
        if (exp_q.size() == 0) begin
            check("strobes_empty", {mem_wvalid, vrf_wvalid, usr_wvalid}, 3'b000);
        end else begin
            hsel = exp_q[0][DW+1:DW];
            check("mem_wvalid", mem_wvalid, hsel == 2'd0);
            check("vrf_wvalid", vrf_wvalid, hsel == 2'd1);
            check("usr_wvalid", usr_wvalid, hsel >= 2'd2);
            check("wdata", wdata, exp_q[0][DW-1:0]);
        end
`ifdef LSU_ROUTER_PERF_EN
        check("rd_cnt", rd_cnt, m_rd_cnt);
        check("wb_cnt", wb_cnt, m_wb_cnt);
`endif
        if (rst) begin
            model_reset();
        end else begin
            acc = rd_valid && exp_rd_ready;
            if (acc) begin
                if (rd_sel == 2'd3) begin
                    m_err   = 1'b1;
                    m_valid = 1'b0;
                end else begin
                    m_valid = 1'b1;
                    m_op1 = (rd_sel == 2'd0) ? mem_op1 : (rd_sel == 2'd1) ? vrf_op1 : usr_op1;
                    m_op2 = (rd_sel == 2'd0) ? mem_op2 : (rd_sel == 2'd1) ? vrf_op2 : usr_op2;
`ifdef LSU_ROUTER_PERF_EN
                    m_rd_cnt = m_rd_cnt + 1;
`endif
                end
            end else if (m_valid && op_ready) begin
                m_valid = 1'b0;
            end
            pop  = (exp_q.size() > 0) && dst_ready;
            push = wb_valid && (exp_q.size() < DEPTH);
            if (pop) begin
                void'(exp_q.pop_front());
`ifdef LSU_ROUTER_PERF_EN
                m_wb_cnt = m_wb_cnt + 1;
`endif
            end
            if (push) exp_q.push_back({wb_sel, wb_data});
        end
        @(negedge clk);
    endtask

    // driver tasks
    task automatic drive_idle();
        rst      = 1'b0;
        rd_valid = 1'b0;
        rd_sel   = 2'd0;
        op_ready = 1'b0;
        wb_valid = 1'b0;
        wb_sel   = 2'd0;
        wb_data  = '0;
        dst_ready = 1'b0;
        mem_op1 = rnd64(); mem_op2 = rnd64();
        vrf_op1 = rnd64(); vrf_op2 = rnd64();
        usr_op1 = rnd64(); usr_op2 = rnd64();
    endtask

    task automatic drive_read(input logic [1:0] sel, input logic [DW-1:0] a, input logic [DW-1:0] b);
        rd_valid = 1'b1;
        rd_sel   = sel;
        case (sel)
            2'd0:    begin mem_op1 = a; mem_op2 = b; end
            2'd1:    begin vrf_op1 = a; vrf_op2 = b; end
            2'd2:    begin usr_op1 = a; usr_op2 = b; end
            default: begin mem_op1 = a; mem_op2 = b; end
        endcase
    endtask

    task automatic drive_wb(input logic [1:0] sel, input logic [DW-1:0] d);
        wb_valid = 1'b1;
        wb_sel   = sel;
        wb_data  = d;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) cycle();
        rst = 1'b0;
    endtask

    logic [1:0] seq_sel [5];
    logic       accepted;

    initial begin
        drive_idle();
        rst = 1'b1;
        @(negedge clk);
        model_reset();
        do_reset(2);

        // reset state
        cycle();
        check("reset_rd_ready", rd_ready, 1'b1);
        check("reset_wb_ready", wb_ready, 1'b1);

        // vrf read with literal operands
        op_ready = 1'b1;
        drive_read(2'd1, 64'hA5, 64'h5A);
        cycle();
        rd_valid = 1'b0;
        op_ready = 1'b0;
        check("vrf_op1_lit", op1, 64'hA5);
        check("vrf_op2_lit", op2, 64'h5A);
        check("vrf_valid_lit", op_valid, 1'b1);
        cycle();

        // backpressure: mem read held, user read stalls until op_ready pulse
        op_ready = 1'b1;
        cycle();
        op_ready = 1'b0;
        drive_read(2'd0, 64'h1111, 64'h2222);
        cycle();
        drive_read(2'd2, 64'h3333, 64'h4444);
        for (int i = 0; i < 3; i++) cycle();
        check("stall_rd_ready", rd_ready, 1'b0);
        check("stall_hold_op1", op1, 64'h1111);
        op_ready = 1'b1;
        cycle();
        rd_valid = 1'b0;
        op_ready = 1'b0;
        check("second_op1", op1, 64'h3333);
        check("second_op2", op2, 64'h4444);
        cycle();

        // reserved source: dropped, sticky error, cleared by reset
        op_ready = 1'b1;
        drive_read(2'd3, rnd64(), rnd64());
        cycle();
        rd_valid = 1'b0;
        check("rsv_err", err_sel, 1'b1);
        check("rsv_valid", op_valid, 1'b0);
        check("rsv_op1_kept", op1, 64'h3333);
        cycle();
        do_reset(1);
        check("rsv_err_clr", err_sel, 1'b0);
        cycle();

        // fill FIFO with dst_ready low, fifth push stalls, then drain in order
        seq_sel[0] = 2'd0; seq_sel[1] = 2'd1; seq_sel[2] = 2'd2;
        seq_sel[3] = 2'd3; seq_sel[4] = 2'd1;
        dst_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_wb(seq_sel[i], 64'h100 + 64'(i));
            cycle();
        end
        check("full_wb_ready", wb_ready, 1'b0);
        drive_wb(seq_sel[4], 64'h104);
        cycle();
        cycle();
        dst_ready = 1'b1;
        accepted  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (!accepted && exp_q.size() < DEPTH) accepted = 1'b1;
            else if (accepted) wb_valid = 1'b0;
            cycle();
        end
        wb_valid = 1'b0;
        check("fifth_entered", accepted, 1'b1);
        cycle();

        // steady state: two entries, push and pop every cycle
        dst_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive_wb(2'($urandom_range(0, 3)), rnd64());
            cycle();
        end
        dst_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive_wb(2'($urandom_range(0, 3)), rnd64());
            cycle();
        end
        wb_valid = 1'b0;
        check("steady_occ", exp_q.size(), 2);
        dst_ready = 1'b0;
        cycle();

        // reset with pending operand and three FIFO entries
        drive_idle();
        cycle();
        dst_ready = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
        dst_ready = 1'b0;
        drive_read(2'd2, rnd64(), rnd64());
        for (int i = 0; i < 3; i++) begin
            drive_wb(2'(i), rnd64());
            cycle();
            rd_valid = 1'b0;
        end
        wb_valid = 1'b0;
        check("pre_rst_valid", op_valid, 1'b1);
        do_reset(1);
        check("post_rst_valid", op_valid, 1'b0);
        check("post_rst_strobes", {mem_wvalid, vrf_wvalid, usr_wvalid}, 3'b000);
        check("post_rst_wb_ready", wb_ready, 1'b1);
        cycle();

        // random traffic
        for (int n = 0; n < 2000; n++) begin
            rst       = ($urandom_range(0, 199) == 0);
            rd_valid  = $urandom_range(0, 1);
            rd_sel    = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            op_ready  = $urandom_range(0, 1);
            wb_valid  = $urandom_range(0, 1);
            wb_sel    = 2'($urandom_range(0, 3));
            wb_data   = rnd64();
            dst_ready = ($urandom_range(0, 2) != 0);
            mem_op1 = rnd64(); mem_op2 = rnd64();
            vrf_op1 = rnd64(); vrf_op2 = rnd64();
            usr_op1 = rnd64(); usr_op2 = rnd64();
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
